// File: rtl/mtr_drv.sv
// mtr_drv: dual H-bridge PWM driver.
//   Turns the balance controller's per-motor 11-bit speed + direction command
//   into complementary fwd/rev PWM pairs. Commands are shadowed only at the
//   period boundary (cnt 2047->0), and a direction reversal blanks the first
//   DEAD_TIME clocks of the new period so the bridge never shoots through.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   pwr_up              drive enable (low forces outputs low next cycle)
//   lft_spd/lft_rev     left motor duty and direction (1 = reverse)
//   rght_spd/rght_rev   right motor duty and direction
//   *_fwd_pwm/*_rev_pwm registered bridge drives
//   period_strt         one-clock pulse on the first output cycle of a period

// Per-motor shadow registers, status FSM and output stage.
module mtr_drv_lane #(
  parameter int DEAD_TIME = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwr_up,
  input  logic        boundary,   // this edge takes cnt 2047->0
  input  logic [10:0] cnt_q,
  input  logic [10:0] cnt_d,
  input  logic [10:0] spd,
  input  logic        rev,
  output logic        fwd_pwm,
  output logic        rev_pwm
);
  localparam logic [10:0] DEAD_T = 11'(DEAD_TIME);

  typedef enum logic [1:0] {S_OFF, S_FWD, S_REV, S_DEAD} state_e;

  state_e      state_q, state_d;
  logic [10:0] spd_sh_q, spd_sh_d;
  logic        rev_sh_q, rev_sh_d;
  logic        dead_q, dead_d;
  logic        fwd_q, fwd_d;
  logic        rvp_q, rvp_d;
  logic        on;

  always_comb begin
    spd_sh_d = spd_sh_q;
    rev_sh_d = rev_sh_q;
    dead_d   = dead_q;
    if (boundary) begin
      spd_sh_d = pwr_up ? spd : 11'd0;
      rev_sh_d = rev;
      dead_d   = (rev != rev_sh_q) && pwr_up;
    end

    // State describes the cycle about to start (cnt_d). DEAD takes priority
    // over OFF so a brief pwr_up dip cannot cut the blanking window short.
    state_d = rev_sh_d ? S_REV : S_FWD;
    if (dead_d && (cnt_d < DEAD_T))            state_d = S_DEAD;
    else if (!pwr_up || (spd_sh_d == 11'd0))   state_d = S_OFF;

    // Live pwr_up gives a 1-clock shutdown; OFF due to spd 0 is covered by
    // the compare, so only DEAD needs to gate the drive here.
    on    = pwr_up && (cnt_q < spd_sh_q) && (state_q != S_DEAD);
    fwd_d = on && !rev_sh_q;
    rvp_d = on &&  rev_sh_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_OFF;
      spd_sh_q <= 11'd0;
      rev_sh_q <= 1'b0;
      dead_q   <= 1'b0;
      fwd_q    <= 1'b0;
      rvp_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      spd_sh_q <= spd_sh_d;
      rev_sh_q <= rev_sh_d;
      dead_q   <= dead_d;
      fwd_q    <= fwd_d;
      rvp_q    <= rvp_d;
    end
  end

  assign fwd_pwm = fwd_q;
  assign rev_pwm = rvp_q;
endmodule

module mtr_drv #(
  parameter int DEAD_TIME = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pwr_up,
  input  logic [10:0] lft_spd,
  input  logic        lft_rev,
  input  logic [10:0] rght_spd,
  input  logic        rght_rev,
  output logic        lft_fwd_pwm,
  output logic        lft_rev_pwm,
  output logic        rght_fwd_pwm,
  output logic        rght_rev_pwm,
  output logic        period_strt
);
  localparam int NUM_LANES = 2;   // lane 0 = left, lane 1 = right

  logic [10:0] cnt_q, cnt_d;
  logic        ps_q, ps_d;
  logic        boundary;

  logic [NUM_LANES-1:0][10:0] spd_vec;
  logic [NUM_LANES-1:0]       rev_vec;
  logic [NUM_LANES-1:0]       fwd_vec;
  logic [NUM_LANES-1:0]       rvp_vec;

  always_comb begin
    cnt_d    = cnt_q + 11'd1;          // natural 11-bit wrap
    boundary = (cnt_q == 11'h7FF);
    ps_d     = (cnt_q == 11'd0);       // lines up with first output cycle
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 11'd0;
      ps_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ps_q  <= ps_d;
    end
  end

  assign spd_vec = {rght_spd, lft_spd};
  assign rev_vec = {rght_rev, lft_rev};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    mtr_drv_lane #(.DEAD_TIME(DEAD_TIME)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .pwr_up   (pwr_up),
      .boundary (boundary),
      .cnt_q    (cnt_q),
      .cnt_d    (cnt_d),
      .spd      (spd_vec[g]),
      .rev      (rev_vec[g]),
      .fwd_pwm  (fwd_vec[g]),
      .rev_pwm  (rvp_vec[g])
    );
  end

  assign lft_fwd_pwm  = fwd_vec[0];
  assign lft_rev_pwm  = rvp_vec[0];
  assign rght_fwd_pwm = fwd_vec[1];
  assign rght_rev_pwm = rvp_vec[1];
  assign period_strt  = ps_q;
endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: per-cycle window model, per-period pulse-count table,
// hand sequences for mid-period changes, pwr_up loss and reset, then random.
module tb_mtr_drv;
  localparam int DT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwr_up = 1'b0;
  logic [10:0] lft_spd = '0, rght_spd = '0;
  logic        lft_rev = 1'b0, rght_rev = 1'b0;
  logic        lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_strt;

  mtr_drv #(.DEAD_TIME(DT)) dut (
    .clk(clk), .rst(rst), .pwr_up(pwr_up),
    .lft_spd(lft_spd), .lft_rev(lft_rev),
    .rght_spd(rght_spd), .rght_rev(rght_rev),
    .lft_fwd_pwm(lft_fwd_pwm), .lft_rev_pwm(lft_rev_pwm),
    .rght_fwd_pwm(rght_fwd_pwm), .rght_rev_pwm(rght_rev_pwm),
    .period_strt(period_strt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each motor owns a pulse window [lo,hi) in period position and a
  // direction, all latched when a period ends.
  int m_cnt = 0;
  int lo[2] = '{0, 0};
  int hi[2] = '{0, 0};
  bit dir[2] = '{0, 0};
  bit e_f[2] = '{0, 0};
  bit e_r[2] = '{0, 0};
  bit e_ps = 0;
  int acc[4] = '{0, 0, 0, 0};   // high-cycle counts: lf, lr, rf, rr

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int  spd[2];
    bit  rv[2];
    bit  nf[2], nr[2], nps;
    int  nlo[2], nhi[2];
    bit  ndir[2];
    int  ncnt;
    spd[0] = int'(lft_spd);  spd[1] = int'(rght_spd);
    rv[0]  = lft_rev;        rv[1]  = rght_rev;
    if (rst) begin
      ncnt = 0; nps = 0;
      for (int i = 0; i < 2; i++) begin
        nf[i] = 0; nr[i] = 0; nlo[i] = 0; nhi[i] = 0; ndir[i] = 0;
      end
    end else begin
      nps  = (m_cnt == 0);
      ncnt = (m_cnt + 1) % 2048;
      for (int i = 0; i < 2; i++) begin
        bit on;
        on    = pwr_up && (m_cnt >= lo[i]) && (m_cnt < hi[i]);
        nf[i] = on && !dir[i];
        nr[i] = on && dir[i];
        nlo[i] = lo[i]; nhi[i] = hi[i]; ndir[i] = dir[i];
        if (m_cnt == 2047) begin
          nhi[i]  = pwr_up ? spd[i] : 0;
          nlo[i]  = (pwr_up && rv[i] != dir[i]) ? DT : 0;
          ndir[i] = rv[i];
        end
      end
    end
    @(posedge clk);
    #1;
    m_cnt = ncnt; e_ps = nps;
    for (int i = 0; i < 2; i++) begin
      lo[i] = nlo[i]; hi[i] = nhi[i]; dir[i] = ndir[i]; e_f[i] = nf[i]; e_r[i] = nr[i];
    end
    check("outputs{lf,lr,rf,rr,ps}",
          int'({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_strt}),
          int'({e_f[0], e_r[0], e_f[1], e_r[1], e_ps}));
    check("no_shoot_through",
          int'((lft_fwd_pwm & lft_rev_pwm) | (rght_fwd_pwm & rght_rev_pwm)), 0);
    acc[0] += int'(lft_fwd_pwm);  acc[1] += int'(lft_rev_pwm);
    acc[2] += int'(rght_fwd_pwm); acc[3] += int'(rght_rev_pwm);
  endtask

  typedef struct {
    logic [10:0] ls; bit lr;
    logic [10:0] rs; bit rr;
    bit          pw;
    int          elf, elr, erf, err;
  } vec_t;

  vec_t tbl[10];

  task automatic apply(input vec_t v);
    lft_spd = v.ls; lft_rev = v.lr; rght_spd = v.rs; rght_rev = v.rr; pwr_up = v.pw;
  endtask

  task automatic clr_acc();
    for (int j = 0; j < 4; j++) acc[j] = 0;
  endtask

  initial begin
    //           ls      lr  rs      rr  pw  lf    lr   rf    rr
    tbl[0] = '{11'd512,  0, 11'd2047, 0, 1, 512,  0,   2047, 0};
    tbl[1] = '{11'd400,  0, 11'd0,    0, 1, 400,  0,   0,    0};
    tbl[2] = '{11'd400,  1, 11'd300,  0, 1, 0,    336, 300,  0};
    tbl[3] = '{11'd40,   0, 11'd2047, 1, 1, 0,    0,   0,    1983};
    tbl[4] = '{11'd40,   0, 11'd2047, 1, 1, 40,   0,   0,    2047};
    tbl[5] = '{11'd1000, 0, 11'd5,    0, 0, 0,    0,   0,    0};
    tbl[6] = '{11'd1000, 0, 11'd5,    0, 1, 1000, 0,   5,    0};
    tbl[7] = '{11'd64,   1, 11'd65,   1, 1, 0,    0,   0,    1};
    tbl[8] = '{11'd0,    0, 11'd65,   1, 1, 0,    0,   0,    65};
    tbl[9] = '{11'd100,  0, 11'd65,   1, 1, 100,  0,   0,    65};

    // Reset
    step(); step();
    check("reset_outputs",
          int'({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_strt}), 0);
    rst = 1'b0;

    // Prime: first period after reset runs with zero shadows
    apply(tbl[0]);
    clr_acc();
    repeat (2048) step();
    check("post_reset_period_idle", acc[0] + acc[1] + acc[2] + acc[3], 0);

    // Table: entry i is observed in the period after it was loaded
    for (int i = 0; i < 10; i++) begin
      clr_acc();
      for (int k = 0; k < 2048; k++) begin
        if (k == 2047 && i < 9) apply(tbl[i + 1]);
        step();
        if (k == 0) check($sformatf("period_strt_v%0d", i), int'(period_strt), 1);
      end
      check($sformatf("v%0d_lft_fwd_cnt", i),  acc[0], tbl[i].elf);
      check($sformatf("v%0d_lft_rev_cnt", i),  acc[1], tbl[i].elr);
      check($sformatf("v%0d_rght_fwd_cnt", i), acc[2], tbl[i].erf);
      check($sformatf("v%0d_rght_rev_cnt", i), acc[3], tbl[i].err);
    end

    // Mid-period command change is ignored until the boundary
    clr_acc();
    for (int k = 0; k < 2048; k++) begin
      if (k == 1000) begin rght_spd = 11'd300; lft_spd = 11'd1000; end
      step();
    end
    check("midchg_rght_rev_cur", acc[3], 65);
    check("midchg_lft_fwd_cur",  acc[0], 100);

    // pwr_up lost at cnt=100, held low across the boundary
    clr_acc();
    for (int k = 0; k < 2048; k++) begin
      if (k == 99) check("pwr_pre_drop_high", int'(lft_fwd_pwm), 1);
      if (k == 100) pwr_up = 1'b0;
      step();
      if (k == 100) check("pwr_drop_next_cycle",
                          int'({lft_fwd_pwm, rght_rev_pwm}), 0);
    end
    check("midchg_rght_rev_new", acc[3], 100);
    check("pwr_drop_lft_cnt",    acc[0], 100);
    clr_acc();
    for (int k = 0; k < 2048; k++) begin
      if (k == 500) pwr_up = 1'b1;
      step();
    end
    check("pwr_off_period", acc[0] + acc[3], 0);
    clr_acc();
    for (int k = 0; k < 2048; k++) begin
      if (k == 700) rst = 1'b1;
      step();
      if (k == 700) begin
        check("rst_mid_pulse",
              int'({lft_fwd_pwm, lft_rev_pwm, rght_fwd_pwm, rght_rev_pwm, period_strt}), 0);
        rst = 1'b0;
        break;
      end
    end
    check("pwr_resume_lft_cnt", acc[0], 700);
    check("pwr_resume_rght_cnt", acc[3], 300);
    step();
    check("rst_period_strt", int'(period_strt), 1);
    clr_acc();
    repeat (2047) step();
    check("rst_speeds_zero", acc[0] + acc[1] + acc[2] + acc[3], 0);

    // Random: commands change anywhere, pwr_up only at the boundary
    for (int p = 0; p < 6; p++) begin
      for (int k = 0; k < 2048; k++) begin
        if ($urandom_range(0, 255) == 0) lft_spd  = 11'($urandom_range(0, 2047));
        if ($urandom_range(0, 255) == 0) rght_spd = 11'($urandom_range(0, 2047));
        if ($urandom_range(0, 127) == 0) lft_rev  = ~lft_rev;
        if ($urandom_range(0, 127) == 0) rght_rev = ~rght_rev;
        if (m_cnt == 2047) pwr_up = ($urandom_range(0, 3) != 0);
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
